// File: rtl/mem_dump_streamer_if.sv
// ----------------------------------------------------------------------------
// mem_dump_streamer_if
//   Bundles the request, memory-read and byte-stream signals of the memory
//   dump streamer.
//   master : the controlling side (issues requests, supplies memory read data,
//            consumes the byte stream)
//   slave  : the streamer itself
//   Signals:
//     start/base_addr/length      request (master -> slave)
//     busy/done/err               status (slave -> master)
//     mem_addr/mem_we/mem_write_size  memory port (slave -> master)
//     mem_rd                      memory read data (master -> slave)
//     out_valid/out_data/out_addr byte stream (slave -> master)
//     out_ready                   stream back-pressure (master -> slave)
// ----------------------------------------------------------------------------
interface mem_dump_streamer_if #(
    parameter int LEN_W = 14
);
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [1:0]       mem_write_size;
    logic [31:0]      mem_rd;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [31:0]      out_addr;
    logic             out_ready;

    modport master (
        output start, base_addr, length, mem_rd, out_ready,
        input  busy, done, err, mem_addr, mem_we, mem_write_size,
               out_valid, out_data, out_addr
    );

    modport slave (
        input  start, base_addr, length, mem_rd, out_ready,
        output busy, done, err, mem_addr, mem_we, mem_write_size,
               out_valid, out_data, out_addr
    );
endinterface

// File: rtl/mem_dump_streamer.sv
// ----------------------------------------------------------------------------
// mem_dump_streamer
//   Reads a byte range of a 32-bit little-endian data memory one word at a
//   time and emits it as a valid/ready byte stream, each byte tagged with its
//   byte address. Read-only: the memory port never writes.
//   Ports:
//     clk  : clock, all state changes on rising edge
//     rst  : asynchronous active-high reset
//     bus  : mem_dump_streamer_if.slave (request, memory read port, stream)
// ----------------------------------------------------------------------------
module mem_dump_streamer #(
    parameter logic [31:0] START_ADDR = 32'h8000_0000,
    parameter int          SIZE       = 8192,
    parameter int          LEN_W      = $clog2(SIZE) + 1
) (
    input logic                clk,
    input logic                rst,
    mem_dump_streamer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EMIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      cur_reg, cur_next;
    logic [LEN_W-1:0] remaining_reg, remaining_next;
    logic [31:0]      wbuf_reg, wbuf_next;
    logic [31:0]      mem_addr_reg, mem_addr_next;

    // Range check done in 33 bits so that a range running past the top of
    // the 32-bit address space is rejected instead of wrapping around.
    logic [32:0] offset;
    logic [32:0] end_offset;
    logic        below_range;
    logic        over_range;
    logic [31:0] fetch_addr;

    assign offset      = {1'b0, bus.base_addr} - {1'b0, START_ADDR};
    assign end_offset  = offset + {{(33-LEN_W){1'b0}}, bus.length};
    assign below_range = bus.base_addr < START_ADDR;
    assign over_range  = end_offset > 33'(SIZE);
    assign fetch_addr  = {cur_reg[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            remaining_reg <= '0;
            wbuf_reg      <= '0;
            mem_addr_reg  <= START_ADDR;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            remaining_reg <= remaining_next;
            wbuf_reg      <= wbuf_next;
            mem_addr_reg  <= mem_addr_next;
        end
    end

    // The byte lane is always cur[1:0]: cur and the lane advance together,
    // so a separate lane counter would only duplicate those two bits.
    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        remaining_next = remaining_reg;
        wbuf_next      = wbuf_reg;
        mem_addr_next  = mem_addr_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    cur_next       = bus.base_addr;
                    remaining_next = bus.length;
                    if (below_range || over_range) begin
                        state_next = ERR;
                    end else if (bus.length == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_addr_next = fetch_addr;
                wbuf_next     = bus.mem_rd;
                state_next    = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    cur_next       = cur_reg + 32'd1;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == LEN_W'(1)) begin
                        state_next = DONE;
                    end else if (cur_reg[1:0] == 2'd3) begin
                        state_next = FETCH;
                    end
                end
            end
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from registered state, so they are stable for the
    // whole cycle and drop to zero as soon as reset is asserted.
    assign bus.busy           = (state_reg == FETCH) || (state_reg == EMIT);
    assign bus.done           = (state_reg == DONE);
    assign bus.err            = (state_reg == ERR);
    assign bus.out_valid      = (state_reg == EMIT);
    assign bus.out_data       = (state_reg == EMIT) ? wbuf_reg[{cur_reg[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.out_addr       = (state_reg == EMIT) ? cur_reg : 32'h0;
    // Memory is only read in FETCH; elsewhere the address holds its last value.
    assign bus.mem_addr       = (state_reg == FETCH) ? fetch_addr : mem_addr_reg;
    assign bus.mem_we         = 1'b0;
    assign bus.mem_write_size = 2'h2;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// ----------------------------------------------------------------------------
// tb_mem_dump_streamer
//   Table-driven bench for mem_dump_streamer: each record gives a request,
//   ready pattern and the expected byte stream / completion status.
//   A reset-mid-transfer sequence is written out by hand.
// ----------------------------------------------------------------------------
module tb_mem_dump_streamer;

    localparam int LEN_W = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_dump_streamer_if #(.LEN_W(LEN_W)) bus ();

    mem_dump_streamer #(
        .START_ADDR (32'h8000_0000),
        .SIZE       (8192),
        .LEN_W      (LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory model: 2048 words, combinational read, poison outside range.
    logic [31:0] mem [0:2047];
    logic [31:0] mem_off;
    always_comb begin
        mem_off = bus.mem_addr - 32'h8000_0000;
        if (bus.mem_addr >= 32'h8000_0000 && mem_off < 32'd8192)
            bus.mem_rd = mem[mem_off[12:2]];
        else
            bus.mem_rd = 32'hDEAD_BEEF;
    end

    typedef struct {
        string            name;
        logic [31:0]      base;
        logic [LEN_W-1:0] len;
        bit               toggle;
        bit               busy_start;
        bit               exp_err;
        int               exp_n;
        logic [63:0]      exp_bytes;   // byte k at [8k +: 8], address base+k
    } vec_t;

    vec_t vecs [11];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   k;
        int   first_valid;
        int   end_cyc;
        bit   saw_done;
        bit   saw_err;
        bit   hs;
        logic pv;
        bit   phs;
        logic [7:0]  pd;
        logic [31:0] pa;
        int   extra;

        k = 0; first_valid = -1; end_cyc = -1;
        saw_done = 0; saw_err = 0; pv = 0; phs = 0; pd = 0; pa = 0;

        @(negedge clk);
        bus.base_addr = v.base;
        bus.length    = v.len;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;

        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (v.busy_start && (cyc == 4 || cyc == 9)) begin
                bus.start     = 1'b1;
                bus.base_addr = 32'h8000_0004;
                bus.length    = 14'd1;
            end
            if (cyc == 1 && v.exp_n > 0)
                check({v.name, "_busy_after_start"}, 64'(bus.busy), 64'd1);
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (pv && !phs) begin
                check({v.name, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
                check({v.name, "_stall_data"}, 64'(bus.out_data), 64'(pd));
                check({v.name, "_stall_addr"}, 64'(bus.out_addr), 64'(pa));
            end
            if (bus.busy && !bus.out_valid)
                check({v.name, "_mem_addr_aligned"}, 64'(bus.mem_addr[1:0]), 64'd0);
            bus.out_ready = v.toggle ? ((cyc % 2) == 1) : 1'b1;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (k < v.exp_n) begin
                    check({v.name, "_data"}, 64'(bus.out_data), 64'(v.exp_bytes[8*k +: 8]));
                    check({v.name, "_addr"}, 64'(bus.out_addr), 64'(v.base + 32'(k)));
                end else begin
                    failures++;
                    $display("FAIL %s_extra_byte: got byte 0x%0h at 0x%0h, expected none",
                             v.name, bus.out_data, bus.out_addr);
                end
                k++;
            end
            pv = bus.out_valid; phs = hs; pd = bus.out_data; pa = bus.out_addr;
            if (bus.done || bus.err) begin
                saw_done = bus.done;
                saw_err  = bus.err;
                end_cyc  = cyc;
                break;
            end
        end

        if (end_cyc < 0) begin
            failures++;
            $display("FAIL %s_timeout: got no done/err within 200 cycles, expected one", v.name);
        end

        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.out_valid) extra++;
        end

        $display("vec %s base=0x%08h len=%0d bytes=%0d done=%0d err=%0d end_cyc=%0d",
                 v.name, v.base, v.len, k, saw_done, saw_err, end_cyc);
        check({v.name, "_byte_count"}, 64'(k), 64'(v.exp_n));
        check({v.name, "_err"}, 64'(saw_err), 64'(v.exp_err));
        check({v.name, "_done"}, 64'(saw_done), 64'(!v.exp_err));
        check({v.name, "_single_pulse"}, 64'(extra), 64'd0);
        if (v.exp_n > 0)
            check({v.name, "_first_valid_cycle"}, 64'(first_valid), 64'd2);
        else
            check({v.name, "_immediate_end_cycle"}, 64'(end_cyc), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   n;

        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[0]    = 32'h4433_2211;
        mem[1]    = 32'h8877_6655;
        mem[2]    = 32'hCCBB_AA99;
        mem[2047] = 32'hF0E0_D0C0;

        vecs[0]  = '{"aligned8",    32'h8000_0000, 14'd8, 1'b0, 1'b0, 1'b0, 8, 64'h8877_6655_4433_2211};
        vecs[1]  = '{"unaligned3",  32'h8000_0002, 14'd3, 1'b0, 1'b0, 1'b0, 3, 64'h0000_0000_0055_4433};
        vecs[2]  = '{"toggle8",     32'h8000_0000, 14'd8, 1'b1, 1'b0, 1'b0, 8, 64'h8877_6655_4433_2211};
        vecs[3]  = '{"len0",        32'h8000_0000, 14'd0, 1'b0, 1'b0, 1'b0, 0, 64'h0};
        vecs[4]  = '{"below",       32'h7FFF_FFFF, 14'd2, 1'b0, 1'b0, 1'b1, 0, 64'h0};
        vecs[5]  = '{"over",        32'h8000_1FFF, 14'd2, 1'b0, 1'b0, 1'b1, 0, 64'h0};
        vecs[6]  = '{"last_byte",   32'h8000_1FFF, 14'd1, 1'b0, 1'b0, 1'b0, 1, 64'h0000_0000_0000_00F0};
        vecs[7]  = '{"last_word",   32'h8000_1FFC, 14'd4, 1'b0, 1'b0, 1'b0, 4, 64'h0000_0000_F0E0_D0C0};
        vecs[8]  = '{"cross_tog",   32'h8000_0005, 14'd6, 1'b1, 1'b0, 1'b0, 6, 64'h0000_BBAA_9988_7766};
        vecs[9]  = '{"busy_start",  32'h8000_0000, 14'd8, 1'b0, 1'b1, 1'b0, 8, 64'h8877_6655_4433_2211};
        vecs[10] = '{"top_of_addr", 32'hFFFF_FFFC, 14'd4, 1'b0, 1'b0, 1'b1, 0, 64'h0};

        bus.start     = 1'b0;
        bus.base_addr = 32'h0;
        bus.length    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",      64'(bus.busy),           64'd0);
        check("rst_done",      64'(bus.done),           64'd0);
        check("rst_err",       64'(bus.err),            64'd0);
        check("rst_valid",     64'(bus.out_valid),      64'd0);
        check("rst_data",      64'(bus.out_data),       64'd0);
        check("rst_addr",      64'(bus.out_addr),       64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),       64'h8000_0000);
        check("rst_mem_we",    64'(bus.mem_we),         64'd0);
        check("rst_wsize",     64'(bus.mem_write_size), 64'd2);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while the third byte (0x33 at ..02) is being presented.
        @(negedge clk);
        bus.base_addr = 32'h8000_0000;
        bus.length    = 14'd8;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        while (!(bus.out_valid && bus.out_addr == 32'h8000_0002) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_byte3_data", 64'(bus.out_data), 64'h33);
        rst = 1'b1;
        #1;
        $display("reset asserted mid-transfer at addr 0x%08h", 32'h8000_0002);
        check("mid_rst_valid",    64'(bus.out_valid), 64'd0);
        check("mid_rst_data",     64'(bus.out_data),  64'd0);
        check("mid_rst_addr",     64'(bus.out_addr),  64'd0);
        check("mid_rst_busy",     64'(bus.busy),      64'd0);
        check("mid_rst_done",     64'(bus.done),      64'd0);
        check("mid_rst_mem_addr", 64'(bus.mem_addr),  64'h8000_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.out_valid || bus.busy) n++;
        end
        check("post_rst_quiet", 64'(n), 64'd0);

        v = vecs[1];
        v.name = "after_rst";
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
